// File: rtl/neuron_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron family.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_LOW, REFRAC} lif_state_t;

    localparam int unsigned N_IN_DEFAULT    = 4;
    localparam int unsigned W_WIDTH_DEFAULT = 8;
    localparam int unsigned SUM_WIDTH       = W_WIDTH_DEFAULT + $clog2(N_IN_DEFAULT);

    // Signed add clamped to the range of a width-bit two's complement value.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned width);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/lif_neuron_sync_if.sv
// Spike handshake bundle: N_IN 4-phase input channels plus one 4-phase output channel.
interface lif_neuron_sync_if #(
    parameter int unsigned N_IN = 4
);
    logic [N_IN-1:0] data_in;
    logic [N_IN-1:0] req_in;
    logic [N_IN-1:0] ack_in;
    logic            data_out;
    logic            req_out;
    logic            ack_out;

    modport slave (
        input  data_in, req_in, ack_out,
        output ack_in, data_out, req_out
    );

    modport master (
        output data_in, req_in, ack_out,
        input  ack_in, data_out, req_out
    );
endinterface

// File: rtl/lif_neuron_sync_weighted_sum.sv
// Combinational masked sum of N_IN signed weights; channel i contributes when mask[i] is set.
module weighted_sum
    import neuron_pkg::*;
#(
    parameter int unsigned N_IN    = N_IN_DEFAULT,
    parameter int unsigned W_WIDTH = W_WIDTH_DEFAULT,
    parameter int unsigned SUM_W   = SUM_WIDTH
) (
    input  logic [N_IN*W_WIDTH-1:0] weights,
    input  logic [N_IN-1:0]         mask,
    output logic signed [SUM_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (mask[i])
                sum = sum + SUM_W'($signed(weights[i*W_WIDTH +: W_WIDTH]));
        end
    end

endmodule

// File: rtl/lif_neuron_sync.sv
// Clocked leaky integrate-and-fire neuron with 4-phase spike channels.
// Optional periodic leak is compiled in when LIF_LEAK_EN is defined.
module lif_neuron_sync
    import neuron_pkg::*;
#(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned W_WIDTH       = 8,
    parameter int unsigned POT_WIDTH     = 16,
    parameter int signed   THOLD         = 64,
    parameter int unsigned REFRAC_CYCLES = 4,
    parameter int unsigned LEAK_PERIOD   = 16,
    parameter int unsigned LEAK_SHIFT    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_IN*W_WIDTH-1:0]     weights,
    lif_neuron_sync_if.slave            spk,
    output logic signed [POT_WIDTH-1:0] pot_out
);

    localparam int unsigned SUM_W = W_WIDTH + $clog2(N_IN);
    localparam int unsigned RC_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic signed [POT_WIDTH-1:0] THOLD_P = POT_WIDTH'(THOLD);

    if (N_IN < 1 || LEAK_PERIOD < 1 || LEAK_SHIFT >= POT_WIDTH) begin : g_bad_cfg
    end

    lif_state_t state;
    lif_state_t state_next;

    logic signed [POT_WIDTH-1:0] pot;
    logic signed [POT_WIDTH-1:0] pot_base;
    logic signed [POT_WIDTH-1:0] pot_sum;
    logic signed [POT_WIDTH-1:0] pot_next;
    logic signed [SUM_W-1:0]     sum;
    logic signed [SUM_W-1:0]     sum_eff;
    logic signed [63:0]          sat_wide;
    logic [N_IN-1:0]             ack_q;
    logic [N_IN-1:0]             ack_next;
    logic [N_IN-1:0]             accept;
    logic [RC_W-1:0]             rc_cnt;
    logic [RC_W-1:0]             rc_next;
    logic                        req_q;
    logic                        data_q;
    logic                        open_st;

    assign open_st  = (state == IDLE) || (state == REFRAC);
    assign accept   = open_st ? (spk.req_in & ~ack_q) : '0;
    // Ack rises on accept, holds while req stays high, drops once req is seen low.
    assign ack_next = accept | (ack_q & spk.req_in);

    weighted_sum #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_sum (
        .weights (weights),
        .mask    (accept & spk.data_in),
        .sum     (sum)
    );

    assign sum_eff = (state == REFRAC) ? '0 : sum;

`ifdef LIF_LEAK_EN
    localparam int unsigned LK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

    logic [LK_W-1:0] leak_cnt;
    logic            leak_wrap;

    assign leak_wrap = (leak_cnt == LK_W'(LEAK_PERIOD - 1));
    // Leak acts on the old potential; same-cycle input is added afterwards.
    assign pot_base  = leak_wrap ? (pot - (pot >>> LEAK_SHIFT)) : pot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            leak_cnt <= '0;
        else
            leak_cnt <= leak_wrap ? '0 : leak_cnt + 1'b1;
    end
`else
    assign pot_base = pot;
`endif

    assign sat_wide = sat_add(64'(pot_base), 64'(sum_eff), POT_WIDTH);
    assign pot_sum  = POT_WIDTH'(sat_wide);

    always_comb begin
        state_next = state;
        pot_next   = pot_sum;
        rc_next    = rc_cnt;
        case (state)
            IDLE: begin
                if (pot_sum >= THOLD_P) begin
                    state_next = FIRE;
                    pot_next   = '0;
                end
            end
            FIRE: begin
                if (spk.ack_out)
                    state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!spk.ack_out) begin
                    if (REFRAC_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = REFRAC;
                        rc_next    = RC_W'(REFRAC_CYCLES);
                    end
                end
            end
            REFRAC: begin
                if (rc_cnt <= RC_W'(1)) begin
                    state_next = IDLE;
                    rc_next    = '0;
                end else begin
                    rc_next = rc_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pot    <= '0;
            ack_q  <= '0;
            rc_cnt <= '0;
            req_q  <= 1'b0;
            data_q <= 1'b0;
        end else begin
            state  <= state_next;
            pot    <= pot_next;
            ack_q  <= ack_next;
            rc_cnt <= rc_next;
            req_q  <= (state_next == FIRE);
            data_q <= (state_next == FIRE);
        end
    end

    assign spk.ack_in   = ack_q;
    assign spk.req_out  = req_q;
    assign spk.data_out = data_q;
    assign pot_out      = pot;

endmodule

// File: tb/tb_lif_neuron_sync.sv
// Self-checking bench for lif_neuron_sync: vector table, scoreboard queue, handshake corner sequences.
module tb_lif_neuron_sync;

    localparam int unsigned N_IN = 4;
    localparam int unsigned W_WIDTH = 8;
    localparam int unsigned POT_WIDTH = 16;
`ifdef LIF_LEAK_EN
    localparam int signed THOLD = 100;
`else
    localparam int signed THOLD = 64;
`endif

    typedef struct {
        logic [31:0] w;
        logic [3:0]  mask;
        logic [3:0]  data;
        int          exp_pot;
        bit          exp_fire;
    } vec_t;

    typedef struct {
        int pot;
        bit fire;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [N_IN*W_WIDTH-1:0] weights;
    logic signed [POT_WIDTH-1:0] pot;
    logic [7:0] weights2;
    logic signed [7:0] pot2;

    int unsigned n_cmp;
    int unsigned n_err;
    exp_t exp_q[$];
    vec_t vecs[11];

    lif_neuron_sync_if #(.N_IN(N_IN)) bus ();
    lif_neuron_sync_if #(.N_IN(1)) bus2 ();

    lif_neuron_sync #(
        .N_IN          (N_IN),
        .W_WIDTH       (W_WIDTH),
        .POT_WIDTH     (POT_WIDTH),
        .THOLD         (THOLD),
        .REFRAC_CYCLES (4),
        .LEAK_PERIOD   (16),
        .LEAK_SHIFT    (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .weights (weights),
        .spk     (bus),
        .pot_out (pot)
    );

    lif_neuron_sync #(
        .N_IN          (1),
        .W_WIDTH       (8),
        .POT_WIDTH     (8),
        .THOLD         (64),
        .REFRAC_CYCLES (4),
        .LEAK_PERIOD   (16),
        .LEAK_SHIFT    (3)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .weights (weights2),
        .spk     (bus2),
        .pot_out (pot2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a spike transaction, compare the popped expectation when the acks rise.
    task automatic send(input logic [3:0] mask, input logic [3:0] data);
        int unsigned n;
        exp_t e;
        bus.req_in  = mask;
        bus.data_in = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_in == '0 && n < 20);
        chk("ack_all", longint'(bus.ack_in), longint'(mask));
        if (exp_q.size() == 0) begin
            chk("sb_empty_pop", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("pot", longint'(pot), longint'(e.pot));
            chk("req_out", longint'(bus.req_out), longint'(e.fire));
        end
        bus.req_in  = '0;
        bus.data_in = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_in != '0 && n < 20);
        chk("ack_low", longint'(bus.ack_in), 0);
    endtask

    task automatic finish_fire();
        int unsigned n;
        chk("fire_data", longint'(bus.data_out), 1);
        bus.ack_out = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_out != 1'b0 && n < 20);
        chk("fire_req_drop", longint'(bus.req_out), 0);
        chk("fire_data_drop", longint'(bus.data_out), 0);
        bus.ack_out = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_pot_change(input logic signed [POT_WIDTH-1:0] from, output int unsigned cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (pot == from && cyc < 60);
    endtask

    initial begin
        int unsigned n;
        int unsigned c1;
        int unsigned c2;
        exp_t e;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        weights = '0;
        weights2 = '0;
        bus.req_in = '0;
        bus.data_in = '0;
        bus.ack_out = 1'b0;
        bus2.req_in = '0;
        bus2.data_in = '0;
        bus2.ack_out = 1'b0;

        vecs[0]  = '{32'h0000_0014, 4'b0001, 4'b0001, 20, 1'b0};
        vecs[1]  = '{32'h0000_0014, 4'b0001, 4'b0001, 40, 1'b0};
        vecs[2]  = '{32'h0000_0014, 4'b0001, 4'b0001, 60, 1'b0};
        vecs[3]  = '{32'h0000_0014, 4'b0001, 4'b0001, 0, 1'b1};
        vecs[4]  = '{32'h0000_0014, 4'b0001, 4'b0000, 0, 1'b0};
        vecs[5]  = '{32'h281E_140A, 4'b1111, 4'b1111, 0, 1'b1};
        vecs[6]  = '{32'h281E_140A, 4'b0110, 4'b0110, 50, 1'b0};
        vecs[7]  = '{32'h281E_140A, 4'b1001, 4'b0001, 60, 1'b0};
        vecs[8]  = '{32'h28E2_140A, 4'b0100, 4'b0100, 30, 1'b0};
        vecs[9]  = '{32'h28E2_140A, 4'b1111, 4'b0111, 30, 1'b0};
        vecs[10] = '{32'h28E2_140A, 4'b1000, 4'b1000, 0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pot", longint'(pot), 0);
        chk("rst_req_out", longint'(bus.req_out), 0);
        chk("rst_data_out", longint'(bus.data_out), 0);
        chk("rst_ack_in", longint'(bus.ack_in), 0);
        chk("rst_pot2", longint'(pot2), 0);
        rst_n = 1'b1;
        tick();

`ifdef LIF_LEAK_EN
        weights = 32'h0000_0040;
        e = '{64, 1'b0};
        exp_q.push_back(e);
        send(4'b0001, 4'b0001);
        wait_pot_change(16'sd64, c1);
        chk("leak_first", longint'(pot), 56);
        wait_pot_change(16'sd56, c1);
        chk("leak_second", longint'(pot), 49);
        wait_pot_change(16'sd49, c2);
        chk("leak_third", longint'(pot), 43);
        chk("leak_period", longint'(c2), 16);
`else
        for (int i = 0; i < 11; i++) begin
            weights = vecs[i].w;
            e = '{vecs[i].exp_pot, vecs[i].exp_fire};
            exp_q.push_back(e);
            send(vecs[i].mask, vecs[i].data);
            if (vecs[i].exp_fire)
                finish_fire();
        end

        // Back-pressure while firing, then a refractory spike that must be ignored.
        weights = 32'h281E_140A;
        e = '{0, 1'b1};
        exp_q.push_back(e);
        send(4'b1111, 4'b1111);
        bus.req_in = 4'b0010;
        bus.data_in = 4'b0010;
        repeat (5) tick();
        chk("bp_ack_fire", longint'(bus.ack_in), 0);
        chk("bp_req_held", longint'(bus.req_out), 1);
        bus.ack_out = 1'b1;
        tick();
        chk("bp_req_fall", longint'(bus.req_out), 0);
        chk("bp_data_fall", longint'(bus.data_out), 0);
        chk("bp_ack_wait", longint'(bus.ack_in), 0);
        bus.ack_out = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_in == '0 && n < 10);
        chk("refrac_ack", longint'(bus.ack_in), 2);
        chk("refrac_pot", longint'(pot), 0);
        bus.req_in = '0;
        bus.data_in = '0;
        repeat (8) tick();
        chk("refrac_pot_after", longint'(pot), 0);
        e = '{20, 1'b0};
        exp_q.push_back(e);
        send(4'b0010, 4'b0010);

        // Stray ack_out while idle must not disturb anything.
        bus.ack_out = 1'b1;
        repeat (3) tick();
        chk("stray_ack_req", longint'(bus.req_out), 0);
        chk("stray_ack_pot", longint'(pot), 20);
        bus.ack_out = 1'b0;
        tick();
        e = '{60, 1'b0};
        exp_q.push_back(e);
        send(4'b1000, 4'b1000);

        // Reset in the middle of FIRE with acks still high.
        e = '{0, 1'b1};
        exp_q.push_back(e);
        bus.req_in = 4'b1111;
        bus.data_in = 4'b1111;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack_in == '0 && n < 20);
        e = exp_q.pop_front();
        chk("mid_fire_req", longint'(bus.req_out), longint'(e.fire));
        chk("mid_fire_ack", longint'(bus.ack_in), 15);
        #3;
        rst_n = 1'b0;
        tick();
        chk("mrst_req_out", longint'(bus.req_out), 0);
        chk("mrst_data_out", longint'(bus.data_out), 0);
        chk("mrst_ack_in", longint'(bus.ack_in), 0);
        chk("mrst_pot", longint'(pot), 0);
        bus.req_in = '0;
        bus.data_in = '0;
        rst_n = 1'b1;
        tick();
        e = '{10, 1'b0};
        exp_q.push_back(e);
        send(4'b0001, 4'b0001);
`endif

        // Narrow neuron: negative saturation with no wrap.
        weights2 = 8'h80;
        for (int k = 0; k < 2; k++) begin
            bus2.req_in = 1'b1;
            bus2.data_in = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus2.ack_in == 1'b0 && n < 20);
            chk("sat_ack", longint'(bus2.ack_in), 1);
            chk("sat_pot", longint'(pot2), -128);
            chk("sat_no_fire", longint'(bus2.req_out), 0);
            bus2.req_in = 1'b0;
            bus2.data_in = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus2.ack_in != 1'b0 && n < 20);
        end

        chk("sb_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
